dispatch_unit: RTL and testbench
================================

# dispatch_unit

Parametrised single-issue decode-and-dispatch stage between the Instruction Fetcher and the back end: Reservation Station, Load Store Buffer, Reorder Buffer and Register File. It accepts one RV32I instruction per cycle through a valid/ready handshake and decodes it. It resolves both source operands from the Register File, the ROB or any of `NUM_CDB` same-cycle broadcast channels. It issues a registered, one-cycle dispatch packet with backpressure and misprediction flush.

## Interface
- `ROB_ID_W`, 4, ROB position width; ROB depth = 2^ROB_ID_W; tag width TAG_W = ROB_ID_W+1 (MSB=1 means pending on ROB entry tag[ROB_ID_W-1:0]; 0 means value ready)
- `NUM_CDB`, 2, number of result broadcast channels
- `clk` in 1: clock
- `rst` in 1: synchronous, active-low reset; all state resets while rst==0 at a rising edge
- `rdy` in 1: global enable; low = hold every register, `inst_ready`=0
- `inst_valid` in 1, `inst_ready` out 1, `inst` in 32, `inst_pc` in 32: fetch handshake
- `flush` in 1: ROB misprediction flush
- `reg_rs1`, `reg_rs2` out 5: combinational Register File query from `inst`
- `reg_val1`, `reg_val2` in 32; `reg_tag1`, `reg_tag2` in TAG_W: Register File result
- `rob_q1`, `rob_q2` out ROB_ID_W: combinational ROB query; `rob_ready1/2` in 1; `rob_val1/2` in 32
- `cdb_valid` in NUM_CDB; `cdb_rob_id` in NUM_CDB*ROB_ID_W; `cdb_val` in NUM_CDB*32: broadcasts, channel i in slice i
- `nxt_rob_pos` in ROB_ID_W; `rob_full`, `rs_full`, `lsb_full` in 1
- `rob_en`, `rs_en`, `lsb_en`, `reg_en` out 1: registered one-cycle dispatch strobes
- `op` out 11: {inst[30], funct3, opcode}
- `rs1_val`, `rs2_val`, `imm`, `pc` out 32
- `rs1_tag`, `rs2_tag` out TAG_W
- `rd` out 5
- `rob_id` out ROB_ID_W
- `illegal` out 1

## Operation
- Class from opcode: LOAD (0000011) / STORE (0100011) → mem; OP, OP-IMM, LUI, AUIPC, BRANCH, JAL, JALR → alu; any other opcode → illegal.
- Accept condition: `inst_ready` = rdy & rst & ~flush & ~rob_full & ~(mem ? lsb_full : rs_full). For illegal, only ~rob_full matters. Accept = inst_valid & inst_ready.
- On accept:
  - rob_en=1 always.
  - rs_en=1 for alu; lsb_en=1 for mem; neither for illegal, which sets illegal=1.
  - rob_id = nxt_rob_pos.
- reg_en=1 iff the instruction writes rd (not BRANCH/STORE/illegal) and rd≠0. The Register File renames rd→{1,nxt_rob_pos} at the same edge.
- Immediates, sign-extended: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0). Types with no immediate output imm=0.
- Operand resolution per source, first match wins:
  1. Register index is 0, or the source is unused by the type → val=0, tag=0.
  2. reg_tag MSB=0 → reg_val, tag 0.
  3. rob_ready → rob_val, tag 0.
  4. Lowest-index CDB channel with valid & id==tag → cdb_val, tag 0.
  5. Otherwise → val=0, tag=reg_tag.
- No accept: all strobes are 0 next cycle; data outputs hold their last values.
- flush=1 at edge k: strobes are 0 after edge k regardless of inst_valid, and nothing is accepted in that cycle.
- rdy=0: all outputs and state hold, including asserted strobes; downstream is likewise gated by rdy.

## Timing
- Reset: every output register is 0 (strobes, op, vals, tags, imm, rd, pc, rob_id, illegal).
- `inst_ready`, reg/rob queries: combinational from the current inputs.
- Latency: instruction accepted at edge k → packet and strobes valid in cycle k+1, strobes high for exactly that one cycle unless rdy=0.
- Throughput: one instruction per cycle. Back-to-back dependence (rs of inst N+1 = rd of inst N) resolves through the Register File rename written at edge k, so inst N+1 sees the pending tag {1,rob_id_N}.
- Full flags are sampled in the accept cycle. Consumers assert full when ≤1 slot is free, accounting for the packet in flight.
- flush and accept in the same cycle: flush wins.
- rst low mid-stream: the pending packet is discarded and strobes are 0 on the next cycle.
- ROB position wrap is the ROB's concern; rob_id is copied through unchanged.

## Test plan
- Reset held 2 cycles, then `addi x5,x0,7` at pc 0x100 with nxt_rob_pos=3 → next cycle: rob_en=rs_en=reg_en=1, rd=5, imm=7, rs1_val=0, rs1_tag=0, rob_id=3, pc=0x100.
- `sw x2,-4(x3)` with reg_tag2={1,5}, rob_ready2=0, cdb_valid[1]=1, cdb_rob_id[1]=5, cdb_val[1]=0xDEAD → lsb_en=1, reg_en=0, imm=0xFFFFFFFC, rs2_val=0xDEAD, rs2_tag=0.
- `add x1,x1,x1` then `add x2,x1,x1` back-to-back at nxt_rob_pos 6 then 7 → second packet: rs1_tag=rs2_tag={1,6}.
- rs_full=1 with an alu instruction valid for 3 cycles → inst_ready=0 and no strobes; after rs_full drops → exactly one dispatch.
- flush asserted together with a valid `beq` → no strobes next cycle; an opcode 0x7F instruction → rob_en=1, illegal=1, rs_en=lsb_en=reg_en=0.
- rdy low during a strobe cycle for 2 cycles → strobes and packet hold unchanged, then clear one cycle after rdy returns.

Source files
------------

// File: rtl/dispatch_unit.sv
// Single-issue RV32I decode/dispatch stage: decodes one instruction per cycle,
// resolves operands from RF/ROB/CDB and issues a registered one-cycle packet.
module dispatch_unit #(
  parameter int ROB_ID_W = 4,
  parameter int NUM_CDB  = 2,
  localparam int TAG_W   = ROB_ID_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         inst_valid,
  output logic                         inst_ready,
  input  logic [31:0]                  inst,
  input  logic [31:0]                  inst_pc,
  input  logic                         flush,
  output logic [4:0]                   reg_rs1,
  output logic [4:0]                   reg_rs2,
  input  logic [31:0]                  reg_val1,
  input  logic [31:0]                  reg_val2,
  input  logic [TAG_W-1:0]             reg_tag1,
  input  logic [TAG_W-1:0]             reg_tag2,
  output logic [ROB_ID_W-1:0]          rob_q1,
  output logic [ROB_ID_W-1:0]          rob_q2,
  input  logic                         rob_ready1,
  input  logic                         rob_ready2,
  input  logic [31:0]                  rob_val1,
  input  logic [31:0]                  rob_val2,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]        cdb_val,
  input  logic [ROB_ID_W-1:0]          nxt_rob_pos,
  input  logic                         rob_full,
  input  logic                         rs_full,
  input  logic                         lsb_full,
  output logic                         rob_en,
  output logic                         rs_en,
  output logic                         lsb_en,
  output logic                         reg_en,
  output logic [10:0]                  op,
  output logic [31:0]                  rs1_val,
  output logic [31:0]                  rs2_val,
  output logic [31:0]                  imm,
  output logic [31:0]                  pc,
  output logic [TAG_W-1:0]             rs1_tag,
  output logic [TAG_W-1:0]             rs2_tag,
  output logic [4:0]                   rd,
  output logic [ROB_ID_W-1:0]          rob_id,
  output logic                         illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]       opcode;
  logic             is_mem, is_alu, is_illegal;
  logic             use_rs1, use_rs2, writes_rd;
  logic [31:0]      imm_dec;
  logic             accept;
  logic [31:0]      src1_val, src2_val;
  logic [TAG_W-1:0] src1_tag, src2_tag;

  assign opcode  = inst[6:0];
  assign reg_rs1 = inst[19:15];
  assign reg_rs2 = inst[24:20];
  assign rob_q1  = reg_tag1[ROB_ID_W-1:0];
  assign rob_q2  = reg_tag2[ROB_ID_W-1:0];

  always_comb begin
    is_mem    = 1'b0;
    is_alu    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm_dec   = 32'h0;
    case (opcode)
      OPC_LOAD: begin
        is_mem = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1;
        imm_dec = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        is_mem = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_dec = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_OP: begin
        is_alu = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
      end
      OPC_OPIMM, OPC_JALR: begin
        is_alu = 1'b1; use_rs1 = 1'b1; writes_rd = 1'b1;
        imm_dec = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        is_alu = 1'b1; writes_rd = 1'b1;
        imm_dec = {inst[31:12], 12'h000};
      end
      OPC_BRANCH: begin
        is_alu = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_dec = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        is_alu = 1'b1; writes_rd = 1'b1;
        imm_dec = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: ;
    endcase
    is_illegal = ~is_mem & ~is_alu;
  end

  // Illegal instructions only need a ROB slot so they can trap at commit.
  assign inst_ready = rdy & rst & ~flush & ~rob_full &
                      (is_illegal | (is_mem ? ~lsb_full : ~rs_full));
  assign accept     = inst_valid & inst_ready;

  // Returns {tag, value}; a zero tag means the value is final.
  function automatic logic [TAG_W+31:0] resolve(
    input logic             used,
    input logic [4:0]       idx,
    input logic [31:0]      rval,
    input logic [TAG_W-1:0] rtag,
    input logic             rob_hit,
    input logic [31:0]      rob_value
  );
    logic [TAG_W+31:0] res;
    logic              hit;
    res = {rtag, 32'h0};
    hit = 1'b0;
    if (!used || idx == 5'd0) begin
      res = '0;
    end else if (!rtag[TAG_W-1]) begin
      res = {{TAG_W{1'b0}}, rval};
    end else if (rob_hit) begin
      res = {{TAG_W{1'b0}}, rob_value};
    end else begin
      for (int i = 0; i < NUM_CDB; i++) begin
        if (!hit && cdb_valid[i] &&
            cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == rtag[ROB_ID_W-1:0]) begin
          res = {{TAG_W{1'b0}}, cdb_val[i*32 +: 32]};
          hit = 1'b1;
        end
      end
    end
    return res;
  endfunction

  assign {src1_tag, src1_val} = resolve(use_rs1, inst[19:15], reg_val1, reg_tag1, rob_ready1, rob_val1);
  assign {src2_tag, src2_val} = resolve(use_rs2, inst[24:20], reg_val2, reg_tag2, rob_ready2, rob_val2);

  // Strobes pulse for one cycle per accept; packet fields hold until the next accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rob_en  <= 1'b0;
      rs_en   <= 1'b0;
      lsb_en  <= 1'b0;
      reg_en  <= 1'b0;
      op      <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      rs1_tag <= '0;
      rs2_tag <= '0;
      imm     <= '0;
      pc      <= '0;
      rd      <= '0;
      rob_id  <= '0;
      illegal <= 1'b0;
    end else if (rdy) begin
      rob_en <= accept;
      rs_en  <= accept & is_alu;
      lsb_en <= accept & is_mem;
      reg_en <= accept & writes_rd & (inst[11:7] != 5'd0);
      if (accept) begin
        op      <= {inst[30], inst[14:12], inst[6:0]};
        rs1_val <= src1_val;
        rs2_val <= src2_val;
        rs1_tag <= src1_tag;
        rs2_tag <= src2_tag;
        imm     <= imm_dec;
        pc      <= inst_pc;
        rd      <= inst[11:7];
        rob_id  <= nxt_rob_pos;
        illegal <= is_illegal;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Table-driven bench for dispatch_unit: each row drives one cycle of stimulus,
// and the expected packet is queued and compared one cycle later.
module tb_dispatch_unit;

  typedef struct packed {
    logic        robEn, rsEn, lsbEn, regEn, illegal;
    logic [10:0] op;
    logic [31:0] rs1Val;
    logic [4:0]  rs1Tag;
    logic [31:0] rs2Val;
    logic [4:0]  rs2Tag;
    logic [31:0] imm, pc;
    logic [4:0]  rd;
    logic [3:0]  robId;
  } pkt_t;

  // ctl = {valid, flush, robFull, rsFull, lsbFull}; expStb = {rob, rs, lsb, reg, illegal}
  typedef struct {
    logic [31:0] inst, pc;
    logic [3:0]  nrob;
    logic [4:0]  ctl;
    logic [31:0] val1;
    logic [4:0]  tag1;
    logic [31:0] val2;
    logic [4:0]  tag2;
    logic [1:0]  robRdy;
    logic [31:0] robVal1, robVal2;
    logic [1:0]  cdbValid;
    logic [7:0]  cdbId;
    logic [63:0] cdbVal;
    logic        expReady;
    logic [4:0]  expStb;
    logic [31:0] expImm, expV1;
    logic [4:0]  expT1;
    logic [31:0] expV2;
    logic [4:0]  expT2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, inst_valid, inst_ready, flush;
  logic [31:0] inst, inst_pc;
  logic [4:0]  reg_rs1, reg_rs2;
  logic [31:0] reg_val1, reg_val2;
  logic [4:0]  reg_tag1, reg_tag2;
  logic [3:0]  rob_q1, rob_q2;
  logic        rob_ready1, rob_ready2;
  logic [31:0] rob_val1, rob_val2;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_val;
  logic [3:0]  nxt_rob_pos;
  logic        rob_full, rs_full, lsb_full;
  logic        rob_en, rs_en, lsb_en, reg_en, illegal;
  logic [10:0] op;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic [4:0]  rs1_tag, rs2_tag, rd;
  logic [3:0]  rob_id;

  int   vecCount = 0;
  int   missCount = 0;
  pkt_t expQ[$];
  pkt_t lastPkt;
  vec_t vecs[20];

  always #5 clk = ~clk;

  dispatch_unit #(.ROB_ID_W(4), .NUM_CDB(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .flush(flush),
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
    .reg_val1(reg_val1), .reg_val2(reg_val2), .reg_tag1(reg_tag1), .reg_tag2(reg_tag2),
    .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_ready1(rob_ready1), .rob_ready2(rob_ready2),
    .rob_val1(rob_val1), .rob_val2(rob_val2),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .nxt_rob_pos(nxt_rob_pos), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_en(rob_en), .rs_en(rs_en), .lsb_en(lsb_en), .reg_en(reg_en),
    .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd(rd), .rob_id(rob_id), .illegal(illegal)
  );

  function automatic pkt_t actualPkt();
    return '{rob_en, rs_en, lsb_en, reg_en, illegal, op, rs1_val, rs1_tag,
             rs2_val, rs2_tag, imm, pc, rd, rob_id};
  endfunction

  function automatic pkt_t buildPkt(vec_t v);
    pkt_t p;
    {p.robEn, p.rsEn, p.lsbEn, p.regEn, p.illegal} = v.expStb;
    p.op     = {v.inst[30], v.inst[14:12], v.inst[6:0]};
    p.rs1Val = v.expV1;
    p.rs1Tag = v.expT1;
    p.rs2Val = v.expV2;
    p.rs2Tag = v.expT2;
    p.imm    = v.expImm;
    p.pc     = v.pc;
    p.rd     = v.inst[11:7];
    p.robId  = v.nrob;
    return p;
  endfunction

  task automatic applyStimulus(vec_t v);
    rst         = 1'b1;
    rdy         = 1'b1;
    inst        = v.inst;
    inst_pc     = v.pc;
    nxt_rob_pos = v.nrob;
    {inst_valid, flush, rob_full, rs_full, lsb_full} = v.ctl;
    reg_val1    = v.val1;
    reg_tag1    = v.tag1;
    reg_val2    = v.val2;
    reg_tag2    = v.tag2;
    rob_ready1  = v.robRdy[0];
    rob_ready2  = v.robRdy[1];
    rob_val1    = v.robVal1;
    rob_val2    = v.robVal2;
    cdb_valid   = v.cdbValid;
    cdb_rob_id  = v.cdbId;
    cdb_val     = v.cdbVal;
  endtask

  // A non-accepting cycle clears the strobes but leaves the packet fields alone.
  task automatic expectNext(logic acc, vec_t v);
    if (acc) lastPkt = buildPkt(v);
    else {lastPkt.robEn, lastPkt.rsEn, lastPkt.lsbEn, lastPkt.regEn} = 4'b0000;
    expQ.push_back(lastPkt);
  endtask

  task automatic checkOutput(string name);
    pkt_t expPkt;
    pkt_t gotPkt;
    vecCount++;
    if (expQ.size() == 0) begin
      missCount++;
      $display("[TB] FAIL %s: scoreboard empty, nothing to compare", name);
    end else begin
      expPkt = expQ.pop_front();
      gotPkt = actualPkt();
      if (gotPkt !== expPkt) begin
        missCount++;
        $display("[TB] FAIL %s: got %h expected %h", name, gotPkt, expPkt);
      end
    end
  endtask

  task automatic checkReady(string name, logic expVal);
    vecCount++;
    if (inst_ready !== expVal) begin
      missCount++;
      $display("[TB] FAIL %s: inst_ready got %b expected %b", name, inst_ready, expVal);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h00700293, 32'h100, 4'd3,  5'b10000, 32'h55,   5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'h7,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[1]  = '{32'hFE21AE23, 32'h104, 4'd4,  5'b10000, 32'h1000, 5'h00, 32'h0,   5'h15, 2'b00, 32'h0,    32'h0, 2'b10, 8'h55, {32'hDEAD, 32'hBAD},   1'b1, 5'b10100, 32'hFFFFFFFC, 32'h1000, 5'h00, 32'hDEAD, 5'h00};
    vecs[2]  = '{32'h001080B3, 32'h108, 4'd6,  5'b10000, 32'd10,   5'h00, 32'd10,  5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'h0,        32'd10,   5'h00, 32'd10,   5'h00};
    vecs[3]  = '{32'h00108133, 32'h10C, 4'd7,  5'b10000, 32'h0,    5'h16, 32'h0,   5'h16, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'h0,        32'h0,    5'h16, 32'h0,    5'h16};
    vecs[4]  = '{32'h00832203, 32'h110, 4'd8,  5'b10000, 32'h0,    5'h12, 32'h77,  5'h00, 2'b01, 32'h1234, 32'h0, 2'b01, 8'h02, {32'h0, 32'h999},      1'b1, 5'b10110, 32'h8,        32'h1234, 5'h00, 32'h0,    5'h00};
    vecs[5]  = '{32'hFE838CE3, 32'h114, 4'd9,  5'b10000, 32'h0,    5'h19, 32'h0,   5'h13, 2'b00, 32'h0,    32'h0, 2'b11, 8'h99, {32'hB0, 32'hA0},      1'b1, 5'b11000, 32'hFFFFFFF8, 32'hA0,   5'h00, 32'h0,    5'h13};
    vecs[6]  = '{32'h123454B7, 32'h118, 4'd10, 5'b10000, 32'hAA,   5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'h12345000, 32'h0,    5'h00, 32'h0,    5'h00};
    vecs[7]  = '{32'h010000EF, 32'h11C, 4'd11, 5'b10000, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'd16,       32'h0,    5'h00, 32'h0,    5'h00};
    vecs[8]  = '{32'h00700293, 32'h120, 4'd12, 5'b10100, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b0, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[9]  = '{32'h00700293, 32'h120, 4'd12, 5'b10010, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b0, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = '{32'h00700293, 32'h120, 4'd12, 5'b10000, 32'h55,   5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'h7,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[13] = '{32'h00700293, 32'h124, 4'd13, 5'b00000, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[14] = '{32'h010000EF, 32'h124, 4'd13, 5'b10001, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b11010, 32'd16,       32'h0,    5'h00, 32'h0,    5'h00};
    vecs[15] = '{32'hFE21AE23, 32'h128, 4'd14, 5'b10001, 32'h1000, 5'h00, 32'h0,   5'h15, 2'b00, 32'h0,    32'h0, 2'b10, 8'h55, {32'hDEAD, 32'hBAD},   1'b0, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[16] = '{32'hFE838CE3, 32'h128, 4'd14, 5'b11000, 32'h0,    5'h19, 32'h0,   5'h13, 2'b00, 32'h0,    32'h0, 2'b11, 8'h99, {32'hB0, 32'hA0},      1'b0, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[17] = '{32'h000001FF, 32'h128, 4'd14, 5'b10011, 32'h55,   5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b10001, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[18] = '{32'h00700293, 32'h12C, 4'd15, 5'b00000, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b1, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};
    vecs[19] = '{32'h000001FF, 32'h12C, 4'd15, 5'b10100, 32'h0,    5'h00, 32'h0,   5'h00, 2'b00, 32'h0,    32'h0, 2'b00, 8'h00, 64'h0,                  1'b0, 5'b00000, 32'h0,        32'h0,    5'h00, 32'h0,    5'h00};

    applyStimulus(vecs[0]);
    rst        = 1'b0;
    inst_valid = 1'b1;
    #1;
    checkReady("ready during reset", 1'b0);
    step();
    step();
    lastPkt = '0;
    expQ.push_back(lastPkt);
    checkOutput("reset state");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkReady($sformatf("ready row %0d", i), vecs[i].expReady);
      expectNext(vecs[i].expReady & vecs[i].ctl[4], vecs[i]);
      step();
      checkOutput($sformatf("packet row %0d", i));
    end

    // Stall while a packet is presented: strobes must stay up until rdy returns.
    begin
      vec_t v;
      v = vecs[0];
      v.pc = 32'h200;
      v.nrob = 4'd1;
      applyStimulus(v);
      expectNext(1'b1, v);
      step();
      checkOutput("rdy setup");
      applyStimulus(vecs[6]);
      rdy = 1'b0;
      #1;
      checkReady("ready while rdy low", 1'b0);
      for (int k = 0; k < 2; k++) begin
        expQ.push_back(lastPkt);
        step();
        checkOutput($sformatf("rdy hold %0d", k));
      end
      rdy = 1'b1;
      inst_valid = 1'b0;
      expectNext(1'b0, v);
      step();
      checkOutput("rdy release");
    end

    // Reset mid-stream discards the instruction being offered.
    applyStimulus(vecs[7]);
    expectNext(1'b1, vecs[7]);
    step();
    checkOutput("pre reset");
    applyStimulus(vecs[6]);
    rst = 1'b0;
    #1;
    checkReady("ready mid reset", 1'b0);
    lastPkt = '0;
    expQ.push_back(lastPkt);
    step();
    checkOutput("mid reset");
    applyStimulus(vecs[6]);
    expectNext(1'b1, vecs[6]);
    step();
    checkOutput("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
